miv_timer_sequencer: RTL and testbench

//  APB3 master that sequences a CoreTimer (32-bit, interrupt active-high) instance.
//  - Programs Prescale, Load and Control on a start request.
//  - Services each TIMINT by writing IntClr and counting ticks.
//  - Applies period updates while running, and stops the timer on request.
//  - Sits between the MIV fabric control logic and the timer's APB slave port.

---
 rtl/miv_timer_sequencer.sv | 166 ++++++++++++++++
 tb/tb_miv_timer_sequencer.sv | 406 ++++++++++++++++++++++++++++++++++++++++
 2 files changed

// File: rtl/miv_timer_sequencer.sv
// APB3 write-only master that programs, services and stops a CoreTimer instance.
// Define TIMER_SEQ_BGLOAD_EN to route period updates to BGLoad instead of Load.
module miv_timer_sequencer #(
  parameter int CNT_W   = 16,
  parameter int HOLDOFF = 1
) (
  input  logic             PCLK,
  input  logic             PRESET,
  input  logic             cfg_start,
  input  logic             cfg_stop,
  input  logic             cfg_upd,
  input  logic [31:0]      cfg_period,
  input  logic [3:0]       cfg_prescale,
  input  logic             cfg_oneshot,
  output logic             PSEL,
  output logic             PENABLE,
  output logic             PWRITE,
  output logic [2:0]       PADDR,
  output logic [31:0]      PWDATA,
  input  logic             TIMINT,
  output logic             busy,
  output logic             running,
  output logic             tick,
  output logic [CNT_W-1:0] tick_count
);

  localparam logic [2:0] A_LOAD = 3'd0;
  localparam logic [2:0] A_CTRL = 3'd2;
  localparam logic [2:0] A_PRE  = 3'd3;
  localparam logic [2:0] A_CLR  = 3'd4;
`ifdef TIMER_SEQ_BGLOAD_EN
  localparam logic [2:0] A_UPD  = 3'd7;
`else
  localparam logic [2:0] A_UPD  = 3'd0;
`endif

  typedef enum logic [3:0] {
    S_IDLE, S_PRE, S_LOAD, S_CTRL, S_RUN, S_CLR, S_HOLD, S_UPD, S_STOP
  } state_t;

  state_t      state, state_n;
  logic        acc;
  logic        is_wr;
  logic [2:0]  hold_cnt;
  logic [31:0] period_q, upd_period;
  logic [3:0]  prescale_q;
  logic        oneshot_q;
  logic        pend_stop, pend_upd;
  logic        want_stop, want_upd;

  assign is_wr     = state inside {S_PRE, S_LOAD, S_CTRL, S_CLR, S_UPD, S_STOP};
  assign want_stop = cfg_stop | pend_stop;
  assign want_upd  = cfg_upd | pend_upd;

  // acc marks the ACCESS half of a two-cycle write; every write starts in SETUP.
  always_ff @(posedge PCLK) begin
    if (PRESET) begin
      state <= S_IDLE;
      acc   <= 1'b0;
    end else begin
      state <= state_n;
      acc   <= is_wr & ~acc;
    end
  end

  always_comb begin
    state_n = state;
    case (state)
      S_IDLE: if (cfg_start) state_n = S_PRE;
      S_PRE:  if (acc) state_n = S_LOAD;
      S_LOAD: if (acc) state_n = S_CTRL;
      S_CTRL: if (acc) state_n = S_RUN;
      S_RUN: begin
        if (TIMINT)         state_n = S_CLR;
        else if (want_stop) state_n = S_STOP;
        else if (want_upd)  state_n = S_UPD;
      end
      S_CLR:  if (acc) state_n = S_HOLD;
      S_HOLD: if (hold_cnt == 3'd0) state_n = oneshot_q ? S_IDLE : S_RUN;
      S_UPD:  if (acc) state_n = S_RUN;
      S_STOP: if (acc) state_n = S_IDLE;
      default: state_n = S_IDLE;
    endcase
  end

  // Configuration capture, holdoff countdown and the interrupt counter.
  always_ff @(posedge PCLK) begin
    if (PRESET) begin
      period_q   <= '0;
      prescale_q <= '0;
      oneshot_q  <= 1'b0;
      hold_cnt   <= '0;
      tick_count <= '0;
    end else begin
      if (state == S_IDLE && cfg_start) begin
        period_q   <= cfg_period;
        prescale_q <= cfg_prescale;
        oneshot_q  <= cfg_oneshot;
      end
      if (state == S_CLR && acc) begin
        hold_cnt   <= 3'(HOLDOFF - 1);
        tick_count <= tick_count + CNT_W'(1);
      end else if (state == S_HOLD && hold_cnt != 3'd0) begin
        hold_cnt <= hold_cnt - 3'd1;
      end
    end
  end

  // One-deep stop/upd latches; a latched stop always wins over a latched upd.
  always_ff @(posedge PCLK) begin
    if (PRESET) begin
      pend_stop  <= 1'b0;
      pend_upd   <= 1'b0;
      upd_period <= '0;
    end else if (state == S_RUN) begin
      if (TIMINT) begin
        if (cfg_stop) begin
          pend_stop <= 1'b1;
          pend_upd  <= 1'b0;
        end else if (cfg_upd && !pend_stop) begin
          pend_upd   <= 1'b1;
          upd_period <= cfg_period;
        end
      end else if (want_stop) begin
        pend_stop <= 1'b0;
        pend_upd  <= 1'b0;
      end else if (want_upd) begin
        pend_upd <= 1'b0;
        if (cfg_upd) upd_period <= cfg_period;
      end
    end else if (state != S_IDLE) begin
      if (state_n == S_IDLE) begin
        pend_stop <= 1'b0;
        pend_upd  <= 1'b0;
      end else if (cfg_stop) begin
        pend_stop <= 1'b1;
        pend_upd  <= 1'b0;
      end else if (cfg_upd && !pend_stop) begin
        pend_upd   <= 1'b1;
        upd_period <= cfg_period;
      end
    end
  end

  always_comb begin
    PADDR  = '0;
    PWDATA = '0;
    case (state)
      S_PRE:  begin PADDR = A_PRE;  PWDATA = {28'b0, prescale_q}; end
      S_LOAD: begin PADDR = A_LOAD; PWDATA = period_q; end
      S_CTRL: begin PADDR = A_CTRL; PWDATA = {29'b0, oneshot_q, 2'b11}; end
      S_CLR:  begin PADDR = A_CLR;  PWDATA = '0; end
      S_UPD:  begin PADDR = A_UPD;  PWDATA = upd_period; end
      S_STOP: begin PADDR = A_CTRL; PWDATA = '0; end
      default: begin PADDR = '0; PWDATA = '0; end
    endcase
  end

  assign PSEL    = is_wr;
  assign PENABLE = acc;
  assign PWRITE  = is_wr;
  assign tick    = (state == S_CLR) && acc;
  assign busy    = (state != S_IDLE) && (state != S_RUN);
  assign running = (state == S_RUN) || (state == S_HOLD);

endmodule

// File: tb/tb_miv_timer_sequencer.sv
// Self-checking bench for miv_timer_sequencer: APB writes are collected by a monitor
// and compared against write lists built from the timer-sequencing rules.
module tb_miv_timer_sequencer;

  localparam int CNT_W   = 8;
  localparam int HOLDOFF = 2;
`ifdef TIMER_SEQ_BGLOAD_EN
  localparam logic [2:0] UPD_ADDR = 3'd7;
  localparam bit         BG_OK    = 1'b1;
`else
  localparam logic [2:0] UPD_ADDR = 3'd0;
  localparam bit         BG_OK    = 1'b0;
`endif

  logic PCLK, PRESET, cfg_start, cfg_stop, cfg_upd, cfg_oneshot, TIMINT;
  logic [31:0] cfg_period;
  logic [3:0]  cfg_prescale;
  logic PSEL, PENABLE, PWRITE, busy, running, tick;
  logic [2:0]  PADDR;
  logic [31:0] PWDATA;
  logic [CNT_W-1:0] tick_count;

  int n_checks = 0;
  int n_fail   = 0;
  int model_count = 0;

  logic [35:0] obs[$];
  logic [35:0] exp_q[$];
  logic [34:0] setup_q;
  bit          setup_v = 1'b0;

  miv_timer_sequencer #(.CNT_W(CNT_W), .HOLDOFF(HOLDOFF)) dut (
    .PCLK(PCLK), .PRESET(PRESET),
    .cfg_start(cfg_start), .cfg_stop(cfg_stop), .cfg_upd(cfg_upd),
    .cfg_period(cfg_period), .cfg_prescale(cfg_prescale), .cfg_oneshot(cfg_oneshot),
    .PSEL(PSEL), .PENABLE(PENABLE), .PWRITE(PWRITE), .PADDR(PADDR), .PWDATA(PWDATA),
    .TIMINT(TIMINT), .busy(busy), .running(running), .tick(tick), .tick_count(tick_count)
  );

  initial PCLK = 1'b0;
  always #5 PCLK = ~PCLK;

  // Each completed write is recorded with bit 35 flagging any protocol breach.
  always @(negedge PCLK) begin
    logic err;
    if (PSEL && !PENABLE) begin
      setup_q = {PADDR, PWDATA};
      setup_v = 1'b1;
      if (PWRITE !== 1'b1) obs.push_back({1'b1, PADDR, PWDATA});
    end else if (PSEL && PENABLE) begin
      err = !setup_v || (setup_q !== {PADDR, PWDATA}) || (PWRITE !== 1'b1) ||
            (!BG_OK && PADDR == 3'd7);
      obs.push_back({err, PADDR, PWDATA});
      setup_v = 1'b0;
    end else begin
      if (PENABLE !== 1'b0) obs.push_back({1'b1, PADDR, PWDATA});
      setup_v = 1'b0;
    end
  end

  function automatic logic [35:0] wr(input logic [2:0] a, input logic [31:0] d);
    return {1'b0, a, d};
  endfunction

  task automatic step();
    @(posedge PCLK); #1;
  endtask

  task automatic do_start(input logic [31:0] per, input logic [3:0] pre, input bit os,
                          output int lat);
    cfg_period = per; cfg_prescale = pre; cfg_oneshot = os; cfg_start = 1'b1;
    step();
    cfg_start = 1'b0;
    cfg_period = $urandom; cfg_prescale = 4'($urandom); cfg_oneshot = ~os;
    lat = -1;
    for (int c = 1; c <= 20; c++) begin
      step();
      if (!busy) begin lat = c; break; end
    end
  endtask

  // Raises TIMINT, keeps it high through HOLD, then drops it the way the timer would.
  task automatic drive_int(input bit stop_now, input bit upd_in_clr, input logic [31:0] upd_per,
                           output int ticks, output int holds);
    bit upd_done;
    upd_done = 1'b0; ticks = 0; holds = 0;
    TIMINT = 1'b1;
    if (stop_now) cfg_stop = 1'b1;
    for (int c = 0; c < 30; c++) begin
      step();
      cfg_stop = 1'b0; cfg_upd = 1'b0;
      if (tick) ticks++;
      if (upd_in_clr && !upd_done && busy && !running) begin
        cfg_upd = 1'b1; cfg_period = upd_per; upd_done = 1'b1;
      end
      if (running && busy) begin
        holds++;
        if (holds == HOLDOFF) TIMINT = 1'b0;
      end
      if (!TIMINT && !busy) break;
    end
    TIMINT = 1'b0; cfg_upd = 1'b0;
    repeat (3) begin step(); if (tick) ticks++; end
  endtask

  task automatic wait_quiet(output int cyc);
    cyc = -1;
    for (int c = 0; c < 40; c++) begin
      if (!busy) begin cyc = c; break; end
      step();
    end
  endtask

  task automatic test_reset();
    PRESET = 1'b1;
    repeat (3) step();
    n_checks++;
    if ({PSEL, PENABLE, PWRITE, busy, running, tick} !== 6'b0) begin
      n_fail++; $display("[TB] FAIL reset_flags: got %b want 000000", {PSEL, PENABLE, PWRITE, busy, running, tick});
    end
    n_checks++;
    if (PADDR !== 3'd0 || PWDATA !== 32'd0) begin
      n_fail++; $display("[TB] FAIL reset_bus: got %h/%h want 0/0", PADDR, PWDATA);
    end
    n_checks++;
    if (tick_count !== '0) begin
      n_fail++; $display("[TB] FAIL reset_count: got %0d want 0", tick_count);
    end
    PRESET = 1'b0; model_count = 0;
    step();
    obs.delete();
  endtask

  task automatic test_start();
    int lat;
    obs.delete(); exp_q.delete();
    do_start(32'h10, 4'd2, 1'b0, lat);
    exp_q.push_back(wr(3'd3, 32'd2)); exp_q.push_back(wr(3'd0, 32'h10)); exp_q.push_back(wr(3'd2, 32'd3));
    n_checks++;
    if (lat !== 6) begin n_fail++; $display("[TB] FAIL start_latency: got %0d want 6", lat); end
    n_checks++;
    if (running !== 1'b1 || busy !== 1'b0) begin
      n_fail++; $display("[TB] FAIL start_flags: got running=%b busy=%b want 1/0", running, busy);
    end
    n_checks++;
    if (obs.size() != exp_q.size()) begin
      n_fail++; $display("[TB] FAIL start_writes count: got %0d want %0d", obs.size(), exp_q.size());
    end else foreach (exp_q[i]) begin
      n_checks++;
      if (obs[i] !== exp_q[i]) begin n_fail++; $display("[TB] FAIL start_write[%0d]: got %h want %h", i, obs[i], exp_q[i]); end
    end
  endtask

  task automatic test_tick();
    int t, h;
    obs.delete(); exp_q.delete();
    drive_int(1'b0, 1'b0, 32'd0, t, h);
    model_count++;
    exp_q.push_back(wr(3'd4, 32'd0));
    n_checks++;
    if (t !== 1) begin n_fail++; $display("[TB] FAIL tick_pulses: got %0d want 1", t); end
    n_checks++;
    if (h !== HOLDOFF) begin n_fail++; $display("[TB] FAIL hold_cycles: got %0d want %0d", h, HOLDOFF); end
    n_checks++;
    if (tick_count !== CNT_W'(model_count)) begin
      n_fail++; $display("[TB] FAIL tick_count: got %0d want %0d", tick_count, CNT_W'(model_count));
    end
    n_checks++;
    if (obs.size() != exp_q.size()) begin
      n_fail++; $display("[TB] FAIL tick_writes count: got %0d want %0d", obs.size(), exp_q.size());
    end else foreach (exp_q[i]) begin
      n_checks++;
      if (obs[i] !== exp_q[i]) begin n_fail++; $display("[TB] FAIL tick_write[%0d]: got %h want %h", i, obs[i], exp_q[i]); end
    end
  endtask

  task automatic test_upd();
    int t, h, cyc;
    logic [31:0] p;
    obs.delete(); exp_q.delete();
    cfg_period = 32'h40; cfg_upd = 1'b1;
    step();
    cfg_upd = 1'b0; cfg_period = 32'hDEAD_BEEF;
    wait_quiet(cyc);
    exp_q.push_back(wr(UPD_ADDR, 32'h40));
    p = $urandom;
    drive_int(1'b0, 1'b1, p, t, h);
    wait_quiet(cyc);
    model_count++;
    exp_q.push_back(wr(3'd4, 32'd0)); exp_q.push_back(wr(UPD_ADDR, p));
    n_checks++;
    if (running !== 1'b1 || cyc < 0) begin
      n_fail++; $display("[TB] FAIL upd_running: got running=%b wait=%0d want 1", running, cyc);
    end
    n_checks++;
    if (obs.size() != exp_q.size()) begin
      n_fail++; $display("[TB] FAIL upd_writes count: got %0d want %0d", obs.size(), exp_q.size());
    end else foreach (exp_q[i]) begin
      n_checks++;
      if (obs[i] !== exp_q[i]) begin n_fail++; $display("[TB] FAIL upd_write[%0d]: got %h want %h", i, obs[i], exp_q[i]); end
    end
  endtask

  task automatic test_stop_with_int();
    int t, h, cyc;
    obs.delete(); exp_q.delete();
    drive_int(1'b1, 1'b0, 32'd0, t, h);
    wait_quiet(cyc);
    model_count++;
    exp_q.push_back(wr(3'd4, 32'd0)); exp_q.push_back(wr(3'd2, 32'd0));
    n_checks++;
    if (t !== 1 || tick_count !== CNT_W'(model_count)) begin
      n_fail++; $display("[TB] FAIL stopint_count: got ticks=%0d count=%0d want 1/%0d", t, tick_count, CNT_W'(model_count));
    end
    n_checks++;
    if (running !== 1'b0 || busy !== 1'b0) begin
      n_fail++; $display("[TB] FAIL stopint_idle: got running=%b busy=%b want 0/0", running, busy);
    end
    n_checks++;
    if (obs.size() != exp_q.size()) begin
      n_fail++; $display("[TB] FAIL stopint_writes count: got %0d want %0d", obs.size(), exp_q.size());
    end else foreach (exp_q[i]) begin
      n_checks++;
      if (obs[i] !== exp_q[i]) begin n_fail++; $display("[TB] FAIL stopint_write[%0d]: got %h want %h", i, obs[i], exp_q[i]); end
    end
  endtask

  task automatic test_oneshot();
    int lat, t, h;
    logic [31:0] per;
    per = $urandom;
    obs.delete(); exp_q.delete();
    do_start(per, 4'd9, 1'b1, lat);
    drive_int(1'b0, 1'b0, 32'd0, t, h);
    model_count++;
    exp_q.push_back(wr(3'd3, 32'd9)); exp_q.push_back(wr(3'd0, per));
    exp_q.push_back(wr(3'd2, 32'd7)); exp_q.push_back(wr(3'd4, 32'd0));
    TIMINT = 1'b1;
    repeat (5) step();
    TIMINT = 1'b0;
    n_checks++;
    if (running !== 1'b0 || busy !== 1'b0) begin
      n_fail++; $display("[TB] FAIL oneshot_idle: got running=%b busy=%b want 0/0", running, busy);
    end
    n_checks++;
    if (obs.size() != exp_q.size()) begin
      n_fail++; $display("[TB] FAIL oneshot_writes count: got %0d want %0d", obs.size(), exp_q.size());
    end else foreach (exp_q[i]) begin
      n_checks++;
      if (obs[i] !== exp_q[i]) begin n_fail++; $display("[TB] FAIL oneshot_write[%0d]: got %h want %h", i, obs[i], exp_q[i]); end
    end
  endtask

  task automatic test_dropped();
    int lat;
    obs.delete();
    cfg_stop = 1'b1; cfg_upd = 1'b1; step(); cfg_stop = 1'b0; cfg_upd = 1'b0;
    repeat (4) step();
    n_checks++;
    if (obs.size() != 0 || running !== 1'b0) begin
      n_fail++; $display("[TB] FAIL idle_drop: got writes=%0d running=%b want 0/0", obs.size(), running);
    end
    do_start(32'h55, 4'd1, 1'b0, lat);
    obs.delete();
    cfg_start = 1'b1; step(); cfg_start = 1'b0;
    repeat (4) step();
    n_checks++;
    if (obs.size() != 0 || running !== 1'b1 || busy !== 1'b0) begin
      n_fail++; $display("[TB] FAIL run_start_drop: got writes=%0d running=%b busy=%b want 0/1/0", obs.size(), running, busy);
    end
    cfg_stop = 1'b1; step(); cfg_stop = 1'b0;
    wait_quiet(lat);
  endtask

  task automatic test_random();
    int lat, t, h, cyc, ticks, exp_ticks;
    bit alive, os;
    logic [31:0] per, p;
    logic [3:0] pre;
    for (int it = 0; it < 16; it++) begin
      obs.delete(); exp_q.delete();
      per = $urandom; pre = 4'($urandom_range(0, 15)); os = ($urandom_range(0, 3) == 0);
      do_start(per, pre, os, lat);
      exp_q.push_back(wr(3'd3, {28'd0, pre})); exp_q.push_back(wr(3'd0, per));
      exp_q.push_back(wr(3'd2, {29'd0, os, 2'b11}));
      alive = 1'b1; ticks = 0; exp_ticks = 0;
      for (int op = 0; op < int'($urandom_range(1, 4)); op++) begin
        if (!alive) break;
        repeat ($urandom_range(0, 3)) step();
        if ($urandom_range(0, 1) == 1) begin
          drive_int(1'b0, 1'b0, 32'd0, t, h);
          ticks += t; exp_ticks++; model_count++;
          exp_q.push_back(wr(3'd4, 32'd0));
          if (os) alive = 1'b0;
        end else begin
          p = $urandom; cfg_period = p; cfg_upd = 1'b1;
          step();
          cfg_upd = 1'b0; cfg_period = $urandom;
          wait_quiet(cyc);
          exp_q.push_back(wr(UPD_ADDR, p));
        end
      end
      if (alive) begin
        cfg_stop = 1'b1; step(); cfg_stop = 1'b0;
        wait_quiet(cyc);
        exp_q.push_back(wr(3'd2, 32'd0));
      end
      n_checks++;
      if (lat !== 6 || ticks !== exp_ticks || running !== 1'b0) begin
        n_fail++; $display("[TB] FAIL rand%0d_status: got lat=%0d ticks=%0d running=%b want 6/%0d/0", it, lat, ticks, running, exp_ticks);
      end
      n_checks++;
      if (tick_count !== CNT_W'(model_count)) begin
        n_fail++; $display("[TB] FAIL rand%0d_count: got %0d want %0d", it, tick_count, CNT_W'(model_count));
      end
      n_checks++;
      if (obs.size() != exp_q.size()) begin
        n_fail++; $display("[TB] FAIL rand%0d_writes count: got %0d want %0d", it, obs.size(), exp_q.size());
      end else foreach (exp_q[i]) begin
        n_checks++;
        if (obs[i] !== exp_q[i]) begin n_fail++; $display("[TB] FAIL rand%0d_write[%0d]: got %h want %h", it, i, obs[i], exp_q[i]); end
      end
    end
  endtask

  task automatic test_reset_mid_transfer();
    logic [31:0] per;
    per = $urandom;
    obs.delete(); exp_q.delete();
    cfg_period = per; cfg_prescale = 4'd5; cfg_oneshot = 1'b0; cfg_start = 1'b1;
    step();
    cfg_start = 1'b0;
    repeat (3) step();
    n_checks++;
    if (PSEL !== 1'b1 || PENABLE !== 1'b1 || PADDR !== 3'd0) begin
      n_fail++; $display("[TB] FAIL load_access: got sel=%b en=%b addr=%0d want 1/1/0", PSEL, PENABLE, PADDR);
    end
    PRESET = 1'b1;
    step();
    n_checks++;
    if ({PSEL, PENABLE, PWRITE, busy, running, tick} !== 6'b0 || PADDR !== 3'd0 || PWDATA !== 32'd0) begin
      n_fail++; $display("[TB] FAIL midreset_outputs: got %b addr=%0d data=%h want all 0", {PSEL, PENABLE, PWRITE, busy, running, tick}, PADDR, PWDATA);
    end
    n_checks++;
    if (tick_count !== '0) begin n_fail++; $display("[TB] FAIL midreset_count: got %0d want 0", tick_count); end
    PRESET = 1'b0; model_count = 0;
    repeat (4) step();
    exp_q.push_back(wr(3'd3, 32'd5)); exp_q.push_back(wr(3'd0, per));
    n_checks++;
    if (obs.size() != exp_q.size()) begin
      n_fail++; $display("[TB] FAIL midreset_writes count: got %0d want %0d", obs.size(), exp_q.size());
    end else foreach (exp_q[i]) begin
      n_checks++;
      if (obs[i] !== exp_q[i]) begin n_fail++; $display("[TB] FAIL midreset_write[%0d]: got %h want %h", i, obs[i], exp_q[i]); end
    end
  endtask

  task automatic test_wrap();
    int lat, t, h, ticks, cyc;
    ticks = 0;
    do_start(32'h100, 4'd0, 1'b0, lat);
    for (int i = 0; i < (1 << CNT_W) - 1; i++) begin
      drive_int(1'b0, 1'b0, 32'd0, t, h);
      ticks += t; model_count++;
    end
    n_checks++;
    if (tick_count !== {CNT_W{1'b1}}) begin
      n_fail++; $display("[TB] FAIL wrap_max: got %0d want %0d", tick_count, (1 << CNT_W) - 1);
    end
    drive_int(1'b0, 1'b0, 32'd0, t, h);
    ticks += t; model_count++;
    n_checks++;
    if (tick_count !== CNT_W'(model_count) || tick_count !== '0) begin
      n_fail++; $display("[TB] FAIL wrap_zero: got %0d want 0", tick_count);
    end
    n_checks++;
    if (ticks !== (1 << CNT_W)) begin n_fail++; $display("[TB] FAIL wrap_ticks: got %0d want %0d", ticks, 1 << CNT_W); end
    cfg_stop = 1'b1; step(); cfg_stop = 1'b0;
    wait_quiet(cyc);
    obs.delete();
  endtask

  initial begin
    PRESET = 1'b1; cfg_start = 1'b0; cfg_stop = 1'b0; cfg_upd = 1'b0;
    cfg_period = '0; cfg_prescale = '0; cfg_oneshot = 1'b0; TIMINT = 1'b0;
    test_reset();
    test_start();
    test_tick();
    test_upd();
    test_stop_with_int();
    test_oneshot();
    test_dropped();
    test_random();
    test_reset_mid_transfer();
    test_wrap();
    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

  initial begin
    #2000000;
    $display("[TB] FAIL watchdog: got timeout want completion");
    $fatal(1, "[TB] watchdog expired");
  end

endmodule
